// File: rtl/apb_req_arbiter_if.sv
// Requester and APB bus bundle for apb_req_arbiter.
// master = arbiter side, slave = requesters plus APB slave side.
interface apb_req_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              wr0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;
  logic              err0;

  logic              req1;
  logic              wr1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;
  logic              err1;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  req0, wr0, addr0, wdata0,
    output done0, rdata0, err0,
    input  req1, wr1, addr1, wdata1,
    output done1, rdata1, err1,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    output req0, wr0, addr0, wdata0,
    input  done0, rdata0, err0,
    output req1, wr1, addr1, wdata1,
    input  done1, rdata1, err1,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin APB master; one transfer at a time, all outputs registered.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                PCLK,
  input logic                PRESET,
  apb_req_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_ptr;
  logic              r_owner;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_done0;
  logic              r_done1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_elig0;
  logic w_elig1;
  logic w_grant;
  logic w_port;
  logic w_complete;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_tcnt;
  logic       r_err0;
  logic       r_err1;
  logic       w_abort;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_tcnt <= 8'd0;
    end else if (r_state == S_SETUP) begin
      r_tcnt <= 8'd0;
    end else if (r_state == S_ACCESS && !bus.PREADY) begin
      r_tcnt <= r_tcnt + 8'd1;
    end
  end
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A requester whose done is still high has not had a chance to drop req yet.
  always_comb begin
    w_elig0    = bus.req0 & ~r_done0;
    w_elig1    = bus.req1 & ~r_done1;
    w_next     = r_state;
    w_grant    = 1'b0;
    w_port     = r_ptr;
    w_complete = 1'b0;
`ifdef APB_TIMEOUT_EN
    w_abort    = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_elig0 || w_elig1) begin
          w_grant = 1'b1;
          w_port  = (w_elig0 && w_elig1) ? r_ptr : w_elig1;
          w_next  = S_SETUP;
        end
      end
      S_SETUP: w_next = S_ACCESS;
      S_ACCESS: begin
        if (bus.PREADY) begin
          w_complete = 1'b1;
          w_next     = S_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (r_tcnt == TCNT_LAST) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_psel    <= (w_next != S_IDLE);
      r_penable <= (w_next == S_ACCESS);
      if (w_grant) begin
        r_owner  <= w_port;
        r_pwrite <= w_port ? bus.wr1    : bus.wr0;
        r_paddr  <= w_port ? bus.addr1  : bus.addr0;
        r_pwdata <= w_port ? bus.wdata1 : bus.wdata0;
        if (w_elig0 && w_elig1) r_ptr <= ~w_port;
      end
      if (w_complete) begin
        if (r_owner) begin
          r_done1 <= 1'b1;
          if (!r_pwrite) r_rdata1 <= bus.PRDATA;
        end else begin
          r_done0 <= 1'b1;
          if (!r_pwrite) r_rdata0 <= bus.PRDATA;
        end
      end
`ifdef APB_TIMEOUT_EN
      if (w_abort) begin
        if (r_owner) r_done1 <= 1'b1;
        else         r_done0 <= 1'b1;
      end
`endif
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      r_err0 <= w_abort & ~r_owner;
      r_err1 <= w_abort &  r_owner;
    end
  end
  assign bus.err0 = r_err0;
  assign bus.err1 = r_err1;
`else
  assign bus.err0 = 1'b0;
  assign bus.err1 = 1'b0;
`endif

  assign bus.PSEL    = r_psel;
  assign bus.PENABLE = r_penable;
  assign bus.PWRITE  = r_pwrite;
  assign bus.PADDR   = r_paddr;
  assign bus.PWDATA  = r_pwdata;
  assign bus.done0   = r_done0;
  assign bus.done1   = r_done1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;

endmodule
